// File: rtl/registro_desplazamiento_32.sv
// registro_desplazamiento_32: 32-bit shift register split into 4-bit slices with a
// per-slice serial output and an automatic burst engine (N shifts + DONE pulse).
// Optional feature macro: PARIDAD_EN adds the PAR output (XOR reduction of Q).
module registro_desplazamiento_32 #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SLICE = 4,
   parameter int unsigned LEN_W = 6,
   localparam int unsigned NS = WIDTH / SLICE
) (
   input  logic             CLK,
   input  logic             RESET_L,
   input  logic             ENB,
   input  logic [1:0]       MODO,
   input  logic             DIR,
   input  logic             S_IN,
   input  logic [WIDTH-1:0] D,
   input  logic             START,
   input  logic [LEN_W-1:0] LEN,
   output logic [WIDTH-1:0] Q,
   output logic [NS-1:0]    S_OUT,
   output logic             BUSY,
   output logic             DONE
`ifdef PARIDAD_EN
   ,
   output logic             PAR
`endif
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BURST = 2'd1;
   localparam logic [1:0] ST_FIN   = 2'd2;

   localparam logic [1:0] MODO_SHIFT  = 2'b00;
   localparam logic [1:0] MODO_ROTATE = 2'b01;
   localparam logic [1:0] MODO_LOAD   = 2'b10;

   logic [1:0]       state_q, state_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic             dir_q, dir_d;
   logic             rot_q, rot_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [NS-1:0]    s_out_q, s_out_d;

   // Operation selected for this cycle, from either the manual inputs or the burst latch
   logic do_shift, do_load, op_dir, op_rot;
   logic shift_in;

   // Burst FSM and manual-operation decode
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      dir_d    = dir_q;
      rot_d    = rot_q;
      do_shift = 1'b0;
      do_load  = 1'b0;
      op_dir   = DIR;
      op_rot   = (MODO == MODO_ROTATE);
      case (state_q)
         ST_IDLE: begin
            // START wins over a manual op requested in the same cycle
            if (START) begin
               dir_d   = DIR;
               rot_d   = (MODO == MODO_ROTATE);
               cnt_d   = LEN;
               state_d = (LEN != '0) ? ST_BURST : ST_FIN;
            end else if (ENB) begin
               do_shift = (MODO == MODO_SHIFT) || (MODO == MODO_ROTATE);
               do_load  = (MODO == MODO_LOAD);
            end
         end
         ST_BURST: begin
            do_shift = 1'b1;
            op_dir   = dir_q;
            op_rot   = rot_q;
            cnt_d    = cnt_q - 1'b1;
            if (cnt_q == LEN_W'(1)) begin
               state_d = ST_FIN;
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Datapath: load, or one-bit shift/rotate capturing each slice's outgoing bit
   always_comb begin
      q_d      = q_q;
      s_out_d  = s_out_q;
      shift_in = 1'b0;
      if (do_load) begin
         q_d = D;
      end else if (do_shift) begin
         if (!op_dir) begin
            shift_in = op_rot ? q_q[WIDTH-1] : S_IN;
            q_d      = {q_q[WIDTH-2:0], shift_in};
            for (int i = 0; i < int'(NS); i++) begin
               s_out_d[i] = q_q[SLICE*i + SLICE - 1];
            end
         end else begin
            shift_in = op_rot ? q_q[0] : S_IN;
            q_d      = {shift_in, q_q[WIDTH-1:1]};
            for (int i = 0; i < int'(NS); i++) begin
               s_out_d[i] = q_q[SLICE*i];
            end
         end
      end
   end

   // State and data registers; reset aborts any burst without a DONE pulse
   always_ff @(posedge CLK or negedge RESET_L) begin
      if (!RESET_L) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
         rot_q   <= 1'b0;
         q_q     <= '0;
         s_out_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
         rot_q   <= rot_d;
         q_q     <= q_d;
         s_out_q <= s_out_d;
      end
   end

   assign Q     = q_q;
   assign S_OUT = s_out_q;
   assign BUSY  = (state_q != ST_IDLE);
   assign DONE  = (state_q == ST_FIN);

`ifdef PARIDAD_EN
   assign PAR = ^q_q;
`endif

endmodule
